// File: rtl/sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// sync_gen_pkg
// Shared types and helpers for the sync pulse generator.
//   state_t       : generator FSM states (IDLE, PULSE, GAP)
//   cfg_t         : configuration record at the default counter width
//   clamp_period  : effective period, never shorter than 2 cycles
//   clamp_width   : effective width, always leaves at least one inactive cycle
// Optional feature macro used by the generator: SYNC_GEN_DE_EN.
// -----------------------------------------------------------------------------
package sync_gen_pkg;

   localparam int unsigned SG_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   typedef struct packed {
      logic [SG_CNT_W-1:0] period;
      logic [SG_CNT_W-1:0] width;
      logic                pol;
   } cfg_t;

   function automatic int unsigned clamp_period(input int unsigned p);
      return (p < 32'd2) ? 32'd2 : p;
   endfunction

   function automatic int unsigned clamp_width(input int unsigned w,
                                               input int unsigned peff);
      return (w > (peff - 32'd1)) ? (peff - 32'd1) : w;
   endfunction

endpackage

// File: rtl/sync_cfg_shadow.sv
// -----------------------------------------------------------------------------
// sync_cfg_shadow
// Double-buffered configuration: a pending register written by the load
// strobe and an active register updated only when the generator opens an
// apply window (period wrap or idle). Values are clamped on transfer.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_load                 capture i_period/i_width/i_pol into pending
//   i_period/i_width/i_pol requested configuration
//   i_window               generator is at an edge where config may change
//   o_act_period           currently active (clamped) period
//   o_eff_period           (SYNC_GEN_DE_EN only) period governing the next edge
//   o_eff_width/o_eff_pol  width/polarity governing the next edge
//   o_ack                  registered strobe: pending config became active
// Optional feature macro: SYNC_GEN_DE_EN (exposes o_eff_period).
// -----------------------------------------------------------------------------
module sync_cfg_shadow
   import sync_gen_pkg::*;
#(
   parameter int unsigned CNT_W      = SG_CNT_W,
   parameter int unsigned DEF_PERIOD = 800,
   parameter int unsigned DEF_WIDTH  = 96,
   parameter bit          DEF_POL    = 1'b0
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_period,
   input  logic [CNT_W-1:0] i_width,
   input  logic             i_pol,
   input  logic             i_window,
   output logic [CNT_W-1:0] o_act_period,
`ifdef SYNC_GEN_DE_EN
   output logic [CNT_W-1:0] o_eff_period,
`endif
   output logic [CNT_W-1:0] o_eff_width,
   output logic             o_eff_pol,
   output logic             o_ack
);

   localparam logic [CNT_W-1:0] DEF_PEFF = CNT_W'(clamp_period(DEF_PERIOD));
   localparam logic [CNT_W-1:0] DEF_WEFF =
      CNT_W'(clamp_width(DEF_WIDTH, clamp_period(DEF_PERIOD)));

   logic             r_pend;
   logic [CNT_W-1:0] r_pend_period;
   logic [CNT_W-1:0] r_pend_width;
   logic             r_pend_pol;
   logic [CNT_W-1:0] r_act_period;
   logic [CNT_W-1:0] r_act_width;
   logic             r_act_pol;
   logic             r_ack;

   logic             w_apply;
   logic [CNT_W-1:0] w_pend_peff;
   logic [CNT_W-1:0] w_pend_weff;
   logic [CNT_W-1:0] w_eff_period;
   logic [CNT_W-1:0] w_eff_width;
   logic             w_eff_pol;

   // Apply uses the flag/data registered before this edge, so a load landing
   // on the same edge is held for the next window.
   always_comb begin
      w_apply      = r_pend & i_window;
      w_pend_peff  = CNT_W'(clamp_period(32'(r_pend_period)));
      w_pend_weff  = CNT_W'(clamp_width(32'(r_pend_width), 32'(w_pend_peff)));
      w_eff_period = r_act_period;
      w_eff_width  = r_act_width;
      w_eff_pol    = r_act_pol;
      if (w_apply) begin
         w_eff_period = w_pend_peff;
         w_eff_width  = w_pend_weff;
         w_eff_pol    = r_pend_pol;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend        <= 1'b0;
         r_pend_period <= '0;
         r_pend_width  <= '0;
         r_pend_pol    <= 1'b0;
         r_act_period  <= DEF_PEFF;
         r_act_width   <= DEF_WEFF;
         r_act_pol     <= DEF_POL;
         r_ack         <= 1'b0;
      end else begin
         r_pend <= i_load | (r_pend & ~w_apply);
         if (i_load) begin
            r_pend_period <= i_period;
            r_pend_width  <= i_width;
            r_pend_pol    <= i_pol;
         end
         if (w_apply) begin
            r_act_period <= w_eff_period;
            r_act_width  <= w_eff_width;
            r_act_pol    <= w_eff_pol;
         end
         r_ack <= w_apply;
      end
   end

   assign o_act_period = r_act_period;
`ifdef SYNC_GEN_DE_EN
   assign o_eff_period = w_eff_period;
`endif
   assign o_eff_width  = w_eff_width;
   assign o_eff_pol    = w_eff_pol;
   assign o_ack        = r_ack;

endmodule

// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
// Periodic sync pulse source with programmable period, width and polarity.
// Configuration is double-buffered and only switches on a period boundary.
// Ports:
//   PCLK        pixel clock (rising edge)
//   RESET_N     asynchronous active-low reset
//   EN          run enable; low returns to IDLE
//   CFG_PERIOD  requested period (cycles)
//   CFG_WIDTH   requested pulse width (cycles)
//   CFG_POL     requested polarity (1 = active-high)
//   CFG_LOAD    capture CFG_* into the pending register
//   CFG_ACK     pending config became active this cycle
//   S           registered sync output
//   SOP         start-of-period strobe (CNT == 0 while running)
//   CNT         position within the current period
//   DE          data enable window (only with SYNC_GEN_DE_EN)
// Optional feature macro: SYNC_GEN_DE_EN (DE port, DE_BACK/DE_FRONT).
// -----------------------------------------------------------------------------
module sync_pulse_gen
   import sync_gen_pkg::*;
#(
   parameter int unsigned CNT_W      = SG_CNT_W,
   parameter int unsigned DEF_PERIOD = 800,
   parameter int unsigned DEF_WIDTH  = 96,
   parameter bit          DEF_POL    = 1'b0
`ifdef SYNC_GEN_DE_EN
   ,
   parameter int unsigned DE_BACK    = 48,
   parameter int unsigned DE_FRONT   = 16
`endif
)(
   input  logic             PCLK,
   input  logic             RESET_N,
   input  logic             EN,
   input  logic [CNT_W-1:0] CFG_PERIOD,
   input  logic [CNT_W-1:0] CFG_WIDTH,
   input  logic             CFG_POL,
   input  logic             CFG_LOAD,
   output logic             CFG_ACK,
   output logic             S,
   output logic             SOP,
`ifdef SYNC_GEN_DE_EN
   output logic             DE,
`endif
   output logic [CNT_W-1:0] CNT
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_s;
   logic             w_s_nxt;
   logic             r_sop;
   logic             w_sop_nxt;

   logic             w_wrap;
   logic             w_window;
   logic [CNT_W-1:0] w_act_period;
   logic [CNT_W-1:0] w_eff_width;
   logic             w_eff_pol;

`ifdef SYNC_GEN_DE_EN
   logic             r_de;
   logic             w_de_nxt;
   logic [CNT_W-1:0] w_eff_period;
`endif

   sync_cfg_shadow #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH),
      .DEF_POL    (DEF_POL)
   ) u_shadow (
      .i_clk        (PCLK),
      .i_rst_n      (RESET_N),
      .i_load       (CFG_LOAD),
      .i_period     (CFG_PERIOD),
      .i_width      (CFG_WIDTH),
      .i_pol        (CFG_POL),
      .i_window     (w_window),
      .o_act_period (w_act_period),
`ifdef SYNC_GEN_DE_EN
      .o_eff_period (w_eff_period),
`endif
      .o_eff_width  (w_eff_width),
      .o_eff_pol    (w_eff_pol),
      .o_ack        (CFG_ACK)
   );

   // Config may change at a wrap while running, or on any edge out of IDLE.
   always_comb begin
      w_wrap   = (r_state != IDLE) && (r_cnt == (w_act_period - CNT_W'(1)));
      w_window = (r_state == IDLE) || (EN && w_wrap);
   end

   // Output levels are derived from the counter value being registered, so
   // S/SOP/DE always describe CNT in the same cycle.
   always_comb begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_s_nxt     = ~w_eff_pol;
      w_sop_nxt   = 1'b0;
`ifdef SYNC_GEN_DE_EN
      w_de_nxt    = 1'b0;
`endif
      if (EN) begin
         if ((r_state == IDLE) || w_wrap) begin
            w_cnt_nxt = '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
         w_sop_nxt = (w_cnt_nxt == '0);
         if (w_cnt_nxt < w_eff_width) begin
            w_state_nxt = PULSE;
            w_s_nxt     = w_eff_pol;
         end else begin
            w_state_nxt = GAP;
            w_s_nxt     = ~w_eff_pol;
         end
`ifdef SYNC_GEN_DE_EN
         // 32-bit compare keeps a crossed window from wrapping around.
         w_de_nxt = ((32'(w_cnt_nxt)) >= (32'(w_eff_width) + DE_BACK)) &&
                    ((32'(w_cnt_nxt) + DE_FRONT) < 32'(w_eff_period));
`endif
      end
   end

   always_ff @(posedge PCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_s     <= ~DEF_POL;
         r_sop   <= 1'b0;
`ifdef SYNC_GEN_DE_EN
         r_de    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_s     <= w_s_nxt;
         r_sop   <= w_sop_nxt;
`ifdef SYNC_GEN_DE_EN
         r_de    <= w_de_nxt;
`endif
      end
   end

   assign S   = r_s;
   assign SOP = r_sop;
   assign CNT = r_cnt;
`ifdef SYNC_GEN_DE_EN
   assign DE  = r_de;
`endif

endmodule

// File: tb/tb_sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_sync_pulse_gen
// Directed stimulus pushes hand-computed per-period expectations (length,
// cycles with S high, S level at CNT 0, CFG_ACK at SOP, DE cycles) into a
// queue; a monitor measures each completed period and compares on the next SOP.
// Optional feature macro: SYNC_GEN_DE_EN (DE port checked when defined).
// -----------------------------------------------------------------------------
module tb_sync_pulse_gen;
   import sync_gen_pkg::*;

   logic        PCLK;
   logic        RESET_N;
   logic        EN;
   logic [15:0] CFG_PERIOD;
   logic [15:0] CFG_WIDTH;
   logic        CFG_POL;
   logic        CFG_LOAD;
   logic        CFG_ACK;
   logic        S;
   logic        SOP;
   logic [15:0] CNT;
`ifdef SYNC_GEN_DE_EN
   logic        DE;
`endif

   sync_pulse_gen #(
      .CNT_W      (16),
      .DEF_PERIOD (800),
      .DEF_WIDTH  (96),
      .DEF_POL    (1'b0)
   ) dut (
      .PCLK       (PCLK),
      .RESET_N    (RESET_N),
      .EN         (EN),
      .CFG_PERIOD (CFG_PERIOD),
      .CFG_WIDTH  (CFG_WIDTH),
      .CFG_POL    (CFG_POL),
      .CFG_LOAD   (CFG_LOAD),
      .CFG_ACK    (CFG_ACK),
      .S          (S),
      .SOP        (SOP),
`ifdef SYNC_GEN_DE_EN
      .DE         (DE),
`endif
      .CNT        (CNT)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   typedef struct {
      int len;
      int high;
      bit s0;
      bit ack;
      int de;
   } rec_t;

   rec_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic void push(input int len, input int high, input bit s0,
                                input bit ack, input int de);
      rec_t r;
      r.len = len; r.high = high; r.s0 = s0; r.ack = ack; r.de = de;
      exp_q.push_back(r);
   endfunction

   // ---------------- monitor ----------------
   int cur_len, cur_high, cur_de;
   bit cur_s0, cur_ack, in_per, cnt_bad;

   initial begin
      in_per = 1'b0;
      cur_len = 0; cur_high = 0; cur_de = 0;
      cur_s0 = 1'b0; cur_ack = 1'b0; cnt_bad = 1'b0;
   end

   always @(negedge PCLK) begin
      if (CFG_ACK) chk("ack_only_on_sop", int'(SOP), 1);
      if (SOP) begin
         if (in_per) begin
            chk("period_queue_len", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               rec_t e;
               e = exp_q.pop_front();
               chk("period_len", cur_len, e.len);
               chk("period_high", cur_high, e.high);
               chk("period_s0", int'(cur_s0), int'(e.s0));
               chk("period_ack", int'(cur_ack), int'(e.ack));
               chk("period_cnt_seq", int'(cnt_bad), 0);
`ifdef SYNC_GEN_DE_EN
               chk("period_de", cur_de, e.de);
`endif
            end
         end
         in_per   = 1'b1;
         cur_len  = 0;
         cur_high = 0;
         cur_de   = 0;
         cur_s0   = S;
         cur_ack  = CFG_ACK;
         cnt_bad  = 1'b0;
      end else if (CNT == 16'd0) begin
         in_per = 1'b0;
      end
      if (in_per) begin
         if (int'(CNT) != cur_len) cnt_bad = 1'b1;
         cur_len++;
         if (S) cur_high++;
`ifdef SYNC_GEN_DE_EN
         if (DE) cur_de++;
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge PCLK);
      #1;
   endtask

   task automatic wait_cnt(input int k);
      int n;
      n = 0;
      while ((int'(CNT) != k) && (n < 2000)) begin
         step();
         n++;
      end
      if (int'(CNT) != k) chk("wait_cnt_timeout", int'(CNT), k);
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < max_cyc)) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic load(input cfg_t c);
      CFG_PERIOD = c.period;
      CFG_WIDTH  = c.width;
      CFG_POL    = c.pol;
      CFG_LOAD   = 1'b1;
      step();
      CFG_LOAD   = 1'b0;
   endtask

   function automatic cfg_t mk(input int p, input int w, input bit pol);
      cfg_t c;
      c.period = 16'(p);
      c.width  = 16'(w);
      c.pol    = pol;
      return c;
   endfunction

   // Default period: 800 cycles, 96 low, 704 high; DE window 144..783.
   localparam int DEF_DE = 640;

   initial begin
      RESET_N    = 1'b0;
      EN         = 1'b0;
      CFG_PERIOD = '0;
      CFG_WIDTH  = '0;
      CFG_POL    = 1'b0;
      CFG_LOAD   = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_S", int'(S), 1);
      chk("rst_SOP", int'(SOP), 0);
      chk("rst_CNT", int'(CNT), 0);
      chk("rst_ACK", int'(CFG_ACK), 0);
`ifdef SYNC_GEN_DE_EN
      chk("rst_DE", int'(DE), 0);
`endif

      // Defaults running
      EN = 1'b1;
      RESET_N = 1'b1;
      push(800, 704, 1'b0, 1'b0, DEF_DE);
      push(800, 704, 1'b0, 1'b0, DEF_DE);
      drain(3000);

      // P=10 W=3 POL=1 loaded mid-period at CNT=400
      push(800, 704, 1'b0, 1'b0, DEF_DE);
      wait_cnt(400);
      load(mk(10, 3, 1'b1));
      push(10, 3, 1'b1, 1'b1, 0);
      push(10, 3, 1'b1, 1'b0, 0);
      push(10, 3, 1'b1, 1'b0, 0);
      drain(2000);

      // W=0: S stays inactive (low for POL=1)
      push(10, 3, 1'b1, 1'b0, 0);
      wait_cnt(0);
      load(mk(10, 0, 1'b1));
      push(10, 0, 1'b0, 1'b1, 0);
      push(10, 0, 1'b0, 1'b0, 0);
      drain(2000);

      // W=12 P=10 POL=0: 9 active-low, 1 high
      push(10, 0, 1'b0, 1'b0, 0);
      wait_cnt(0);
      load(mk(10, 12, 1'b0));
      push(10, 1, 1'b0, 1'b1, 0);
      push(10, 1, 1'b0, 1'b0, 0);
      drain(2000);

      // P=1 W=1 POL=1: period clamps to 2, width to 1
      push(10, 1, 1'b0, 1'b0, 0);
      wait_cnt(0);
      load(mk(1, 1, 1'b1));
      push(2, 1, 1'b1, 1'b1, 0);
      push(2, 1, 1'b1, 1'b0, 0);
      push(2, 1, 1'b1, 1'b0, 0);
      drain(2000);

      // Back to P=10 W=3 POL=1
      push(2, 1, 1'b1, 1'b0, 0);
      wait_cnt(0);
      load(mk(10, 3, 1'b1));
      push(10, 3, 1'b1, 1'b1, 0);
      drain(2000);

      // Two loads in one period: last wins, single ACK
      push(10, 3, 1'b1, 1'b0, 0);
      wait_cnt(0);
      load(mk(10, 2, 1'b1));
      wait_cnt(2);
      load(mk(10, 5, 1'b1));
      push(10, 5, 1'b1, 1'b1, 0);
      push(10, 5, 1'b1, 1'b0, 0);
      drain(2000);

      // Load on the wrap edge: deferred one period
      push(10, 5, 1'b1, 1'b0, 0);
      wait_cnt(9);
      load(mk(10, 7, 1'b1));
      push(10, 5, 1'b1, 1'b0, 0);
      push(10, 7, 1'b1, 1'b1, 0);
      push(10, 7, 1'b1, 1'b0, 0);
      drain(2000);

      // Apply and load on the same wrap: W=4 applied, W=6 held and applied next
      push(10, 7, 1'b1, 1'b0, 0);
      wait_cnt(0);
      load(mk(10, 4, 1'b1));
      wait_cnt(9);
      load(mk(10, 6, 1'b1));
      push(10, 4, 1'b1, 1'b1, 0);
      push(10, 6, 1'b1, 1'b1, 0);
      push(10, 6, 1'b1, 1'b0, 0);
      drain(2000);

      // EN low at CNT=5: immediate idle, no pulse completion
      wait_cnt(5);
      EN = 1'b0;
      step();
      chk("en_low_S", int'(S), 0);
      chk("en_low_CNT", int'(CNT), 0);
      chk("en_low_SOP", int'(SOP), 0);
`ifdef SYNC_GEN_DE_EN
      chk("en_low_DE", int'(DE), 0);
`endif
      step();
      step();
      EN = 1'b1;
      push(10, 6, 1'b1, 1'b0, 0);
      step();
      chk("restart_SOP", int'(SOP), 1);
      chk("restart_CNT", int'(CNT), 0);
      chk("restart_S", int'(S), 1);
      drain(2000);

      // Reset mid-pulse with a pending load: back to defaults, pending dropped
      load(mk(30, 5, 1'b1));
      wait_cnt(3);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("midrst_S", int'(S), 1);
      chk("midrst_CNT", int'(CNT), 0);
      chk("midrst_SOP", int'(SOP), 0);
      chk("midrst_ACK", int'(CFG_ACK), 0);
      step();
      step();
      push(800, 704, 1'b0, 1'b0, DEF_DE);
      RESET_N = 1'b1;
      drain(3000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
